// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back port arbiter: FSM state encoding,
// source identifiers and default widths.
package wb_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wb_state_t;

   localparam logic SRC_EXU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin pick between EXU and LSU. i_favour names the source
// that wins when both request; a lone requester always wins.
// o_grant is one-hot: bit 0 = EXU, bit 1 = LSU, all-zero when idle.
module wb_rr_pick
   import wb_arb_pkg::*;
(
   input  logic       i_req_exu,
   input  logic       i_req_lsu,
   input  logic       i_favour,
   output logic [1:0] o_grant
);

   // Resolve the grant from the two requests and the favoured source
   always_comb begin
      o_grant = '0;
      if (i_req_exu && i_req_lsu) begin
         o_grant = (i_favour == SRC_LSU) ? 2'b10 : 2'b01;
      end else if (i_req_exu) begin
         o_grant = 2'b01;
      end else if (i_req_lsu) begin
         o_grant = 2'b10;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: EXU and LSU results share one register-file write
// port. A result is accepted in IDLE and written in the following WRITE cycle.
// Optional performance counters are built only when WB_ARB_PERF_EN is defined;
// otherwise the o_perf_* outputs are tied to zero.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_exu_valid,
   output logic              o_exu_ready,
   input  logic              i_exu_wena,
   input  logic [ADDR_W-1:0] i_exu_rd,
   input  logic [DATA_W-1:0] i_exu_data,
   input  logic              i_lsu_valid,
   output logic              o_lsu_ready,
   input  logic              i_lsu_wena,
   input  logic [ADDR_W-1:0] i_lsu_rd,
   input  logic [DATA_W-1:0] i_lsu_data,
   output logic              o_rf_wen,
   output logic [ADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_done,
   output logic              o_done_src,
   output logic [31:0]       o_perf_exu_cnt,
   output logic [31:0]       o_perf_lsu_cnt,
   output logic [31:0]       o_perf_conflict_cnt
);

   wb_state_t         state_q, state_d;
   logic              favour_q;
   logic              held_src_q;
   logic              held_wena_q;
   logic [ADDR_W-1:0] held_rd_q;
   logic [DATA_W-1:0] held_data_q;
   logic [1:0]        grant;
   logic              exu_rdy, lsu_rdy;
   logic              accept;
   logic              accept_src;

   wb_rr_pick u_pick (
      .i_req_exu (i_exu_valid),
      .i_req_lsu (i_lsu_valid),
      .i_favour  (favour_q),
      .o_grant   (grant)
   );

   // Outputs: readies in IDLE, write port and retirement in WRITE.
   // Gating with i_rst_n keeps readies low in reset and drops a held write
   // that coincides with reset.
   always_comb begin
      exu_rdy    = 1'b0;
      lsu_rdy    = 1'b0;
      o_rf_wen   = 1'b0;
      o_done     = 1'b0;
      o_done_src = SRC_EXU;
      o_rf_waddr = held_rd_q;
      o_rf_wdata = held_data_q;
      if (i_rst_n) begin
         if (state_q == IDLE) begin
            exu_rdy = grant[0];
            lsu_rdy = grant[1];
         end else begin
            o_rf_wen   = held_wena_q & (held_rd_q != '0);
            o_done     = 1'b1;
            o_done_src = held_src_q;
         end
      end
   end

   assign o_exu_ready = exu_rdy;
   assign o_lsu_ready = lsu_rdy;
   assign accept      = exu_rdy | lsu_rdy;
   assign accept_src  = lsu_rdy ? SRC_LSU : SRC_EXU;

   // Next state: accept moves to WRITE, WRITE always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Capture the accepted result and hand the next conflict to the other side
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         favour_q    <= SRC_LSU;
         held_src_q  <= SRC_EXU;
         held_wena_q <= 1'b0;
         held_rd_q   <= '0;
         held_data_q <= '0;
      end else if (accept) begin
         favour_q    <= ~accept_src;
         held_src_q  <= accept_src;
         held_wena_q <= lsu_rdy ? i_lsu_wena : i_exu_wena;
         held_rd_q   <= lsu_rdy ? i_lsu_rd   : i_exu_rd;
         held_data_q <= lsu_rdy ? i_lsu_data : i_exu_data;
      end
   end

`ifdef WB_ARB_PERF_EN
   logic [31:0] exu_cnt_q, lsu_cnt_q, conflict_cnt_q;

   // Transfer and conflict counters, free-running with natural wrap
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         exu_cnt_q      <= '0;
         lsu_cnt_q      <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (exu_rdy) exu_cnt_q <= exu_cnt_q + 32'd1;
         if (lsu_rdy) lsu_cnt_q <= lsu_cnt_q + 32'd1;
         if ((state_q == IDLE) && i_exu_valid && i_lsu_valid)
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign o_perf_exu_cnt      = exu_cnt_q;
   assign o_perf_lsu_cnt      = lsu_cnt_q;
   assign o_perf_conflict_cnt = conflict_cnt_q;
`else
   assign o_perf_exu_cnt      = '0;
   assign o_perf_lsu_cnt      = '0;
   assign o_perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, an
// alternation sequence, and randomized traffic against a transaction model.
module tb_wb_port_arbiter;

`ifdef WB_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ev, lv, ew, lw;
   logic [4:0]  erd, lrd;
   logic [31:0] ed, ld;
   logic        e_ready, l_ready, rf_wen, done, done_src;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, perf_e, perf_l, perf_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_exu_valid         (ev),
      .o_exu_ready         (e_ready),
      .i_exu_wena          (ew),
      .i_exu_rd            (erd),
      .i_exu_data          (ed),
      .i_lsu_valid         (lv),
      .o_lsu_ready         (l_ready),
      .i_lsu_wena          (lw),
      .i_lsu_rd            (lrd),
      .i_lsu_data          (ld),
      .o_rf_wen            (rf_wen),
      .o_rf_waddr          (rf_waddr),
      .o_rf_wdata          (rf_wdata),
      .o_done              (done),
      .o_done_src          (done_src),
      .o_perf_exu_cnt      (perf_e),
      .o_perf_lsu_cnt      (perf_l),
      .o_perf_conflict_cnt (perf_c)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic v_e, input logic v_l,
                        input logic w_e, input logic w_l,
                        input logic [4:0] rd_e, input logic [4:0] rd_l,
                        input logic [31:0] d_e, input logic [31:0] d_l);
      rst_n = r; ev = v_e; lv = v_l; ew = w_e; lw = w_l;
      erd = rd_e; lrd = rd_l; ed = d_e; ld = d_l;
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] xe,
                           input logic [31:0] xl, input logic [31:0] xc);
      chk({tag, "_perf_exu"}, perf_e, PERF ? xe : 32'd0);
      chk({tag, "_perf_lsu"}, perf_l, PERF ? xl : 32'd0);
      chk({tag, "_perf_conf"}, perf_c, PERF ? xc : 32'd0);
   endtask

   typedef struct {
      logic        r, v_e, v_l, w_e, w_l;
      logic [4:0]  rd_e, rd_l;
      logic [31:0] d_e, d_l;
      logic        x_er, x_lr, x_wen;
      logic [4:0]  x_wa;
      logic [31:0] x_wd;
      logic        x_done, x_src;
      logic [31:0] x_pe, x_pl, x_pc;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic v_e, input logic v_l, input logic w_e, input logic w_l,
      input logic [4:0] rd_e, input logic [4:0] rd_l, input logic [31:0] d_e, input logic [31:0] d_l,
      input logic x_er, input logic x_lr, input logic x_wen, input logic [4:0] x_wa,
      input logic [31:0] x_wd, input logic x_done, input logic x_src,
      input logic [31:0] x_pe, input logic [31:0] x_pl, input logic [31:0] x_pc);
      vec_t v;
      v.r = r; v.v_e = v_e; v.v_l = v_l; v.w_e = w_e; v.w_l = w_l;
      v.rd_e = rd_e; v.rd_l = rd_l; v.d_e = d_e; v.d_l = d_l;
      v.x_er = x_er; v.x_lr = x_lr; v.x_wen = x_wen; v.x_wa = x_wa; v.x_wd = x_wd;
      v.x_done = x_done; v.x_src = x_src; v.x_pe = x_pe; v.x_pl = x_pl; v.x_pc = x_pc;
      return v;
   endfunction

   vec_t vt[16];

   typedef struct {
      logic        src;
      logic        wena;
      logic [4:0]  rd;
      logic [31:0] data;
   } xfer_t;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      //          r ev lv ew lw erd lrd  ed            ld             er lr wen wa  wd            dn src pe pl pc
      vt[0]  = mk(0, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            0, 0,  0, 0, 0);
      vt[1]  = mk(1, 1, 0, 1, 0,  3,  0, 32'h1234,     0,             1, 0, 0,  0,  0,            0, 0,  0, 0, 0);
      vt[2]  = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 1,  3,  32'h1234,     1, 0,  1, 0, 0);
      vt[3]  = mk(0, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            0, 0,  1, 0, 0);
      vt[4]  = mk(1, 1, 1, 1, 1,  5,  7, 32'hAAAA,     32'hBBBB,      0, 1, 0,  0,  0,            0, 0,  0, 0, 0);
      vt[5]  = mk(1, 1, 0, 1, 0,  5,  0, 32'hAAAA,     0,             0, 0, 1,  7,  32'hBBBB,     1, 1,  0, 1, 1);
      vt[6]  = mk(1, 1, 0, 1, 0,  5,  0, 32'hAAAA,     0,             1, 0, 0,  0,  0,            0, 0,  0, 1, 1);
      vt[7]  = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 1,  5,  32'hAAAA,     1, 0,  1, 1, 1);
      vt[8]  = mk(1, 0, 1, 0, 1,  0,  0, 0,            32'h5555,      0, 1, 0,  0,  0,            0, 0,  1, 1, 1);
      vt[9]  = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            1, 1,  1, 2, 1);
      vt[10] = mk(1, 1, 1, 1, 1,  9, 10, 32'h1,        32'h2,         1, 0, 0,  0,  0,            0, 0,  1, 2, 1);
      vt[11] = mk(0, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            0, 0,  2, 2, 2);
      vt[12] = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            0, 0,  0, 0, 0);
      vt[13] = mk(1, 1, 1, 1, 1, 11, 12, 32'h3,        32'h4,         0, 1, 0,  0,  0,            0, 0,  0, 0, 0);
      vt[14] = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 1, 12,  32'h4,        1, 1,  0, 1, 1);
      vt[15] = mk(1, 0, 0, 0, 0,  0,  0, 0,            0,             0, 0, 0,  0,  0,            0, 0,  0, 1, 1);

      repeat (2) @(posedge clk);
      #1;

      // Directed vectors: one row per cycle, outputs checked mid-cycle
      for (int i = 0; i < 16; i++) begin
         drive(vt[i].r, vt[i].v_e, vt[i].v_l, vt[i].w_e, vt[i].w_l,
               vt[i].rd_e, vt[i].rd_l, vt[i].d_e, vt[i].d_l);
         #4;
         chk($sformatf("vec%0d_exu_ready", i), e_ready, vt[i].x_er);
         chk($sformatf("vec%0d_lsu_ready", i), l_ready, vt[i].x_lr);
         chk($sformatf("vec%0d_rf_wen", i), rf_wen, vt[i].x_wen);
         chk($sformatf("vec%0d_done", i), done, vt[i].x_done);
         if (vt[i].x_done) chk($sformatf("vec%0d_done_src", i), done_src, vt[i].x_src);
         if (vt[i].x_wen) begin
            chk($sformatf("vec%0d_waddr", i), rf_waddr, vt[i].x_wa);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].x_wd);
         end
         chk_perf($sformatf("vec%0d", i), vt[i].x_pe, vt[i].x_pl, vt[i].x_pc);
         @(posedge clk);
         #1;
      end

      // Both requesters continuously valid for 8 transfers: LSU, EXU, LSU, ...
      begin
         int ek = 0;
         int lk = 0;
         logic [4:0]  h_rd;
         logic [31:0] h_data;
         h_rd = '0;
         h_data = '0;
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(posedge clk);
         #1;
         for (int k = 0; k < 16; k++) begin
            drive(1, 1, 1, 1, 1, 5'(ek + 1), 5'(lk + 17),
                  32'hE000_0000 + 32'(ek), 32'hD000_0000 + 32'(lk));
            #4;
            case (k % 4)
               0: begin
                  chk($sformatf("alt%0d_lsu_ready", k), l_ready, 1'b1);
                  chk($sformatf("alt%0d_exu_ready", k), e_ready, 1'b0);
                  h_rd = lrd; h_data = ld;
               end
               2: begin
                  chk($sformatf("alt%0d_exu_ready", k), e_ready, 1'b1);
                  chk($sformatf("alt%0d_lsu_ready", k), l_ready, 1'b0);
                  h_rd = erd; h_data = ed;
               end
               default: begin
                  chk($sformatf("alt%0d_done", k), done, 1'b1);
                  chk($sformatf("alt%0d_done_src", k), done_src, (k % 4) == 1);
                  chk($sformatf("alt%0d_rf_wen", k), rf_wen, 1'b1);
                  chk($sformatf("alt%0d_waddr", k), rf_waddr, h_rd);
                  chk($sformatf("alt%0d_wdata", k), rf_wdata, h_data);
               end
            endcase
            @(posedge clk);
            #1;
            if (k % 4 == 0) lk++;
            if (k % 4 == 2) ek++;
         end
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
         #4;
         chk_perf("alt_end", 32'd4, 32'd4, 32'd8);
         @(posedge clk);
         #1;
      end

      // Randomized traffic against a transaction-level model
      begin
         bit          busy = 1'b0;
         int          last_win = 0;
         xfer_t       sb[$];
         logic [31:0] m_pe = '0, m_pl = '0, m_pc = '0;
         logic        ep = 1'b0, lp = 1'b0, ewa = 1'b0, lwa = 1'b0;
         logic [4:0]  erv = '0, lrv = '0;
         logic [31:0] edv = '0, ldv = '0;
         // start from a known reset so the model and DUT agree on history
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(posedge clk);
         #1;
         for (int c = 0; c < 600; c++) begin
            logic  r;
            int    win;
            xfer_t x;
            r = ($urandom_range(0, 39) != 0);
            if (!ep && $urandom_range(0, 1) == 1) begin
               ep = 1'b1; ewa = 1'($urandom_range(0, 3) != 0);
               erv = 5'($urandom_range(0, 31)); edv = $urandom;
            end
            if (!lp && $urandom_range(0, 1) == 1) begin
               lp = 1'b1; lwa = 1'($urandom_range(0, 3) != 0);
               lrv = 5'($urandom_range(0, 31)); ldv = $urandom;
            end
            drive(r, ep, lp, ewa, lwa, erv, lrv, edv, ldv);

            win = -1;
            if (r && !busy) begin
               if (ep && lp) win = (last_win == 1) ? 0 : 1;
               else if (ep)  win = 0;
               else if (lp)  win = 1;
            end

            #4;
            chk("rnd_exu_ready", e_ready, win == 0);
            chk("rnd_lsu_ready", l_ready, win == 1);
            if (r && busy && sb.size() > 0) begin
               x = sb[0];
               chk("rnd_done", done, 1'b1);
               chk("rnd_done_src", done_src, x.src);
               chk("rnd_rf_wen", rf_wen, x.wena && (x.rd != 0));
               if (x.wena && (x.rd != 0)) begin
                  chk("rnd_waddr", rf_waddr, x.rd);
                  chk("rnd_wdata", rf_wdata, x.data);
               end
            end else begin
               chk("rnd_done", done, 1'b0);
               chk("rnd_rf_wen", rf_wen, 1'b0);
            end
            chk_perf("rnd", m_pe, m_pl, m_pc);

            if (!r) begin
               busy = 1'b0; last_win = 0; sb.delete();
               m_pe = '0; m_pl = '0; m_pc = '0;
            end else if (busy) begin
               busy = 1'b0;
               if (sb.size() > 0) void'(sb.pop_front());
            end else begin
               if (ep && lp) m_pc = m_pc + 1;
               if (win == 0) begin
                  x.src = 1'b0; x.wena = ewa; x.rd = erv; x.data = edv;
                  sb.push_back(x); busy = 1'b1; last_win = 0; m_pe = m_pe + 1; ep = 1'b0;
               end else if (win == 1) begin
                  x.src = 1'b1; x.wena = lwa; x.rd = lrv; x.data = ldv;
                  sb.push_back(x); busy = 1'b1; last_win = 1; m_pl = m_pl + 1; lp = 1'b0;
               end
            end
            @(posedge clk);
            #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
